// File: rtl/sdram_responder.sv
// sdram_responder: device-side SDRAM target with bank/row tracking, mode register,
// sequential bursts, a CAS-latency read pipeline and a small internal array.
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           addr,
  input  logic [1:0]            ba,
  input  logic [DATA_W/8-1:0]   dqm,
  input  logic                  cke,
  input  logic                  cs,
  input  logic                  ras,
  input  logic                  cas,
  input  logic                  we,
  input  logic [DATA_W-1:0]     dq_in,
  output logic [DATA_W-1:0]     dq_out,
  output logic                  dq_oe,
  output logic                  cmd_err,
  output logic [15:0]           refresh_cnt
);
  localparam int AW = 2 + ROW_BITS + COL_BITS;
  logic [3:0]                r_act;
  logic [3:0][ROW_BITS-1:0]  r_row;
  logic [2:0]                r_bl;
  logic                      r_cl3;
  logic                      r_bst;
  logic                      r_bst_wr;
  logic [1:0]                r_bst_ba;
  logic [ROW_BITS-1:0]       r_bst_row;
  logic [COL_BITS-1:0]       r_bst_col;
  logic [2:0]                r_bst_cnt;
  logic                      r_s1_v;
  logic                      r_s2_v;
  logic [DATA_W-1:0]         r_s1_d;
  logic [DATA_W-1:0]         r_s2_d;
  logic [DATA_W-1:0]         r_mem [2**AW];
  logic [3:0]                w_cmd;
  logic                      w_c_act, w_c_rd, w_c_wr, w_c_pre, w_c_ref, w_c_lmr, w_c_bt;
  logic                      w_on, w_err, w_rw, w_stop, w_beat_v, w_beat_wr, w_rd;
  logic [3:0]                w_len;
  logic [COL_BITS-1:0]       w_mask;
  logic [COL_BITS-1:0]       w_bst_col;
  logic [AW-1:0]             w_idx;
  logic                      w_unused;
  assign w_cmd   = {cs, ras, cas, we};
  assign w_c_act = w_cmd == 4'b0011;
  assign w_c_rd  = w_cmd == 4'b0101;
  assign w_c_wr  = w_cmd == 4'b0100;
  assign w_c_pre = w_cmd == 4'b0010;
  assign w_c_ref = w_cmd == 4'b0001;
  assign w_c_lmr = w_cmd == 4'b0000;
  assign w_c_bt  = w_cmd == 4'b0110;
  assign w_on    = r_act[ba];
  assign w_err   = ((w_c_rd | w_c_wr) & ~w_on) | (w_c_act & w_on) | ((w_c_ref | w_c_lmr) & |r_act);
  assign w_rw    = (w_c_rd | w_c_wr) & w_on;
  assign w_stop  = w_c_bt | (w_c_pre & (addr[10] | ba == r_bst_ba));
  assign w_len   = r_bl == 3'd1 ? 4'd2 : r_bl == 3'd2 ? 4'd4 : r_bl == 3'd3 ? 4'd8 : 4'd1;
  assign w_mask  = COL_BITS'(w_len - 4'd1);
  // burst wraps inside the BL-aligned column block; r_bst_col holds the start column
  assign w_bst_col = (r_bst_col & ~w_mask) | ((r_bst_col + COL_BITS'(r_bst_cnt)) & w_mask);
  assign w_beat_v  = w_rw | (r_bst & ~w_stop);
  assign w_beat_wr = w_rw ? w_c_wr : r_bst_wr;
  assign w_rd      = w_beat_v & ~w_beat_wr;
  assign w_idx     = w_rw ? {ba, r_row[ba], addr[COL_BITS-1:0]} : {r_bst_ba, r_bst_row, w_bst_col};
  assign w_unused  = ^{addr, w_cmd};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act       <= '0;
      r_row       <= '0;
      r_bl        <= '0;
      r_cl3       <= 1'b1;
      r_bst       <= 1'b0;
      r_bst_wr    <= 1'b0;
      r_bst_ba    <= '0;
      r_bst_row   <= '0;
      r_bst_col   <= '0;
      r_bst_cnt   <= '0;
      r_s1_v      <= 1'b0;
      r_s2_v      <= 1'b0;
      r_s1_d      <= '0;
      r_s2_d      <= '0;
      dq_out      <= '0;
      dq_oe       <= 1'b0;
      cmd_err     <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      cmd_err <= cke & w_err;
      if (cke) begin
        if (w_c_act && !w_on) begin
          r_act[ba] <= 1'b1;
          r_row[ba] <= addr[ROW_BITS-1:0];
        end
        if (w_c_pre) begin
          if (addr[10]) r_act <= '0;
          else r_act[ba] <= 1'b0;
        end
        if (w_c_lmr && !(|r_act)) begin
          r_bl  <= addr[2:0];
          r_cl3 <= addr[6:4] != 3'd2;
        end
        if (w_c_ref && !(|r_act)) refresh_cnt <= refresh_cnt + 16'd1;
        if (w_rw) begin
          r_bst     <= w_len != 4'd1;
          r_bst_wr  <= w_c_wr;
          r_bst_ba  <= ba;
          r_bst_row <= r_row[ba];
          r_bst_col <= addr[COL_BITS-1:0];
          r_bst_cnt <= 3'd1;
        end else if (r_bst) begin
          r_bst     <= ~w_stop & (4'(r_bst_cnt) != w_len - 4'd1);
          r_bst_cnt <= r_bst_cnt + 3'd1;
        end
        r_s1_v <= w_rd;
        r_s1_d <= w_rd ? r_mem[w_idx] : '0;
        r_s2_v <= r_s1_v;
        r_s2_d <= r_s1_d;
        dq_oe  <= r_cl3 ? r_s2_v : r_s1_v;
        dq_out <= r_cl3 ? r_s2_d : r_s1_d;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && cke && w_beat_v && w_beat_wr)
      for (int i = 0; i < DATA_W/8; i++)
        if (!dqm[i]) r_mem[w_idx][8*i +: 8] <= dq_in[8*i +: 8];
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed scenarios with a timed read-beat scoreboard.
module tb_sdram_responder;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] addr = '0;
  logic [1:0]  ba = '0;
  logic [3:0]  dqm = '0;
  logic        cke = 1'b1, cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [31:0] dq_in = '0;
  logic [31:0] dq_out;
  logic        dq_oe, cmd_err;
  logic [15:0] refresh_cnt;
  sdram_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .ba(ba), .dqm(dqm), .cke(cke),
    .cs(cs), .ras(ras), .cas(cas), .we(we), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .cmd_err(cmd_err), .refresh_cnt(refresh_cnt)
  );
  always #5 clk = ~clk;
  typedef struct { int c; logic [31:0] d; } beat_t;
  beat_t       q[$];
  int          total = 0, bad = 0, cyc = 0, cl = 3;
  logic [31:0] mdl [1024];
  logic [3:0]  trow [4];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic ck, po;
    logic [31:0] pd;
    beat_t e;
    ck = cke; pd = dq_out; po = dq_oe;
    @(posedge clk); #1;
    cyc++;
    if (!ck) begin
      foreach (q[i]) q[i].c++;
      chk("hold_dq", dq_out, pd);
      chk("hold_oe", 32'(dq_oe), 32'(po));
    end else if (dq_oe) begin
      if (q.size() == 0) chk("unexpected_oe", 32'(dq_oe), 32'd0);
      else begin
        e = q.pop_front();
        chk("beat_cyc", cyc, e.c);
        chk("beat_data", dq_out, e.d);
      end
    end else begin
      chk("idle_dq", dq_out, 32'd0);
      if (q.size() != 0 && q[0].c <= cyc) begin
        e = q.pop_front();
        chk("missed_beat", 32'(dq_oe), 32'd1);
      end
    end
  endtask
  task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    {cs, ras, cas, we} = c; ba = b; addr = a;
  endtask
  task automatic do_cmd(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    cmd(c, b, a); tick(); cmd(NOP, 2'd0, 12'd0);
  endtask
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic push(input int i, input logic [31:0] d);
    q.push_back('{cyc + cl + i, d});
  endtask
  function automatic logic [3:0] bcol(input logic [3:0] col, input int i, input int bl);
    logic [3:0] m;
    m = 4'(bl - 1);
    return (col & ~m) | ((col + 4'(i)) & m);
  endfunction
  task automatic wr(input logic [1:0] b, input logic [3:0] col, input int n,
                    input logic [31:0] base, input logic [31:0] step, input logic [3:0] m);
    logic [31:0] v;
    dqm = m;
    for (int i = 0; i < n; i++) begin
      if (i == 0) cmd(WR, b, {8'd0, col});
      dq_in = base + step * 32'(i);
      v = mdl[{b, trow[b], bcol(col, i, n)}];
      for (int k = 0; k < 4; k++) if (!m[k]) v[8*k +: 8] = dq_in[8*k +: 8];
      mdl[{b, trow[b], bcol(col, i, n)}] = v;
      tick();
      cmd(NOP, 2'd0, 12'd0);
    end
    dqm = '0;
  endtask
  task automatic rd(input logic [1:0] b, input logic [3:0] col, input int n, input int bl);
    for (int i = 0; i < n; i++) push(i, mdl[{b, trow[b], bcol(col, i, bl)}]);
    do_cmd(RD, b, {8'd0, col});
  endtask
  initial begin
    nops(2);
    chk("rst_oe", 32'(dq_oe), 32'd0);
    chk("rst_dq", dq_out, 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_ref", 32'(refresh_cnt), 32'd0);
    rst = 1'b0;
    // BL=4 CL=2 write then read back
    do_cmd(LMR, 2'd0, 12'h022); cl = 2;
    do_cmd(ACT, 2'd1, 12'h003); trow[1] = 4'd3;
    wr(2'd1, 4'd4, 4, 32'hA0, 32'd1, 4'b0000);
    push(0, 32'hA0); push(1, 32'hA1); push(2, 32'hA2); push(3, 32'hA3);
    rd(2'd1, 4'd4, 0, 4);
    nops(6);
    chk("bl4_cl2_done", q.size(), 32'd0);
    // BL=4 CL=3 wrapped read from column 6
    do_cmd(PRE, 2'd0, 12'h400);
    do_cmd(LMR, 2'd0, 12'h032); cl = 3;
    do_cmd(ACT, 2'd1, 12'h003);
    push(0, 32'hA2); push(1, 32'hA3); push(2, 32'hA0); push(3, 32'hA1);
    rd(2'd1, 4'd6, 0, 4);
    nops(7);
    chk("wrap_done", q.size(), 32'd0);
    // byte mask
    wr(2'd1, 4'd8, 4, 32'hFFFF_FFFF, 32'd0, 4'b0000);
    wr(2'd1, 4'd8, 4, 32'h1234_5678, 32'd0, 4'b0101);
    for (int i = 0; i < 4; i++) push(i, 32'h12FF_56FF);
    rd(2'd1, 4'd8, 0, 4);
    nops(7);
    chk("mask_done", q.size(), 32'd0);
    // illegal commands
    cmd(RD, 2'd2, 12'd0); tick(); chk("rd_idle_err", 32'(cmd_err), 32'd1);
    cmd(NOP, 2'd0, 12'd0); tick(); chk("err_pulse", 32'(cmd_err), 32'd0);
    nops(5);
    cmd(ACT, 2'd1, 12'h005); tick(); chk("act_open_err", 32'(cmd_err), 32'd1);
    cmd(NOP, 2'd0, 12'd0);
    rd(2'd1, 4'd4, 4, 4);
    nops(7);
    chk("row_kept_done", q.size(), 32'd0);
    cmd(REF, 2'd0, 12'd0); tick();
    chk("ref_open_err", 32'(cmd_err), 32'd1);
    chk("ref_open_cnt", 32'(refresh_cnt), 32'd0);
    do_cmd(PRE, 2'd0, 12'h400);
    for (int i = 0; i < 3; i++) begin
      cmd(REF, 2'd0, 12'd0); tick();
      chk("ref_ok_err", 32'(cmd_err), 32'd0);
    end
    cmd(NOP, 2'd0, 12'd0);
    chk("ref_cnt3", 32'(refresh_cnt), 32'd3);
    // BL=8 CL=2 read interrupted at beat 2
    do_cmd(LMR, 2'd0, 12'h023); cl = 2;
    do_cmd(ACT, 2'd0, 12'h001); trow[0] = 4'd1;
    wr(2'd0, 4'd0, 8, 32'hB0, 32'd1, 4'b0000);
    wr(2'd0, 4'd8, 8, 32'hC0, 32'd1, 4'b0000);
    rd(2'd0, 4'd0, 3, 8);
    nops(2);
    rd(2'd0, 4'd8, 8, 8);
    nops(10);
    chk("interrupt_done", q.size(), 32'd0);
    // clock suspend mid-burst
    rd(2'd0, 4'd0, 8, 8);
    nops(2);
    cke = 1'b0;
    nops(2);
    cke = 1'b1;
    nops(10);
    chk("suspend_done", q.size(), 32'd0);
    // async reset mid-read
    rd(2'd0, 4'd0, 8, 8);
    nops(2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_oe", 32'(dq_oe), 32'd0);
    chk("async_rst_dq", dq_out, 32'd0);
    q.delete();
    tick();
    rst = 1'b0;
    cmd(RD, 2'd0, 12'd0); tick(); chk("rd_after_rst_err", 32'(cmd_err), 32'd1);
    cmd(NOP, 2'd0, 12'd0);
    nops(4);
    cl = 3;
    do_cmd(ACT, 2'd0, 12'h001);
    rd(2'd0, 4'd3, 1, 1);
    nops(6);
    chk("post_rst_mode_done", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
